// File: rtl/unglom_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : unglom_splitter                                              |
// | Description : Unpacks one WORD_W-bit word into WORD_W/FIELD_W fields,      |
// |               MSB-first by default, LSB-first with UNGLOM_LSB_FIRST_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module unglom_splitter #(
    parameter int WORD_W  = 32,
    parameter int FIELD_W = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WORD_W-1:0]                    in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [FIELD_W-1:0]                   out_data,
    output logic                                 out_last,
    output logic [$clog2(WORD_W/FIELD_W)-1:0]    out_index,
    output logic                                 busy
);

    localparam int c_NFIELDS = WORD_W / FIELD_W;
    localparam int c_IDX_W   = $clog2(c_NFIELDS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NFIELDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]         r_state;
    logic [WORD_W-1:0]  r_held;
    logic [c_IDX_W-1:0] r_index;
    logic [FIELD_W-1:0] r_out_data;
    logic               r_out_last;

    logic               w_out_beat;
    logic               w_final_beat;
    logic               w_accept;
    logic [c_IDX_W-1:0] w_next_index;

    function automatic logic [FIELD_W-1:0] f_field(input logic [WORD_W-1:0] word,
                                                   input logic [c_IDX_W-1:0] idx);
`ifdef UNGLOM_LSB_FIRST_EN
        return word[int'(idx)*FIELD_W +: FIELD_W];
`else
        return word[WORD_W-1-int'(idx)*FIELD_W -: FIELD_W];
`endif
    endfunction

    assign w_out_beat   = (r_state == S_EMIT) && out_ready;
    assign w_final_beat = w_out_beat && (r_index == c_LAST_IDX);
    assign w_next_index = r_index + c_IDX_W'(1);

    // A new word may enter on the same edge the previous word's last field leaves.
    assign in_ready = reset && ((r_state == S_IDLE) || w_final_beat);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_held     <= '0;
            r_index    <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else if (w_accept) begin
            r_state    <= S_EMIT;
            r_held     <= in_data;
            r_index    <= '0;
            r_out_data <= f_field(in_data, '0);
            r_out_last <= 1'b0;
        end else if (w_final_beat) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else if (w_out_beat) begin
            r_index    <= w_next_index;
            r_out_data <= f_field(r_held, w_next_index);
            r_out_last <= (w_next_index == c_LAST_IDX);
        end
    end

    assign out_valid = (r_state == S_EMIT);
    assign busy      = (r_state == S_EMIT);
    assign out_index = r_index;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_unglom_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_unglom_splitter                                           |
// | Description : Directed and random checks of unglom_splitter against a      |
// |               remaining-field-count reference model.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_unglom_splitter;

    localparam int c_WORD_W  = 32;
    localparam int c_FIELD_W = 4;
    localparam int c_NF      = c_WORD_W / c_FIELD_W;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_last;
    logic [2:0]  out_index;
    logic        busy;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_data;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic        b_out_last;
    logic [1:0]  b_out_index;
    logic        b_busy;

    int n_checks = 0;
    int n_errors = 0;

    int          m_rem  = 0;
    logic [31:0] m_word = '0;

    always #5 clk = ~clk;

    unglom_splitter #(.WORD_W(c_WORD_W), .FIELD_W(c_FIELD_W)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_index(out_index), .busy(busy)
    );

    unglom_splitter #(.WORD_W(32), .FIELD_W(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
        .out_last(b_out_last), .out_index(b_out_index), .busy(b_busy)
    );

    // Field k of a word in emission order, from plain shift arithmetic.
    function automatic logic [3:0] exp_field(input logic [31:0] w, input int k);
`ifdef UNGLOM_LSB_FIRST_EN
        return 4'(w >> (c_FIELD_W * k));
`else
        return 4'(w >> (c_WORD_W - c_FIELD_W * (k + 1)));
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare against the model at negedge, then advance the model at posedge.
    task automatic tick();
        logic exp_ir;
        @(negedge clk);
        exp_ir = reset && (m_rem == 0 || (out_ready && m_rem == 1));
        chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_ir});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_rem > 0});
        chk("busy",      {31'd0, busy},      {31'd0, m_rem > 0});
        chk("out_index", {29'd0, out_index}, (m_rem > 0) ? 32'(c_NF - m_rem) : 32'd0);
        if (m_rem > 0) begin
            chk("out_data", {28'd0, out_data}, {28'd0, exp_field(m_word, c_NF - m_rem)});
            chk("out_last", {31'd0, out_last}, {31'd0, m_rem == 1});
        end
        @(posedge clk);
        if (!reset) begin
            m_rem = 0;
        end else begin
            if (m_rem > 0 && out_ready) m_rem--;
            if (in_valid && exp_ir) begin
                m_word = in_data;
                m_rem  = c_NF;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  exp8 [4];
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_out_data", {28'd0, out_data}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        reset = 1'b1;
        tick();

        // Basic word, full throughput
        in_valid = 1'b1; in_data = 32'h12345678;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < c_NF; k++) begin
`ifdef UNGLOM_LSB_FIRST_EN
            chk("basic_data", {28'd0, out_data}, 32'(8 - k));
`else
            chk("basic_data", {28'd0, out_data}, 32'(k + 1));
`endif
            chk("basic_index", {29'd0, out_index}, 32'(k));
            chk("basic_last", {31'd0, out_last}, {31'd0, k == c_NF - 1});
            tick();
        end
        chk("basic_idle", {31'd0, out_valid}, 32'd0);
        tick();

        // Backpressure after the second field
        in_valid = 1'b1; in_data = 32'h12345678;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_data", {28'd0, out_data}, {28'd0, exp_field(32'h12345678, 1)});
            chk("bp_index", {29'd0, out_index}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        repeat (c_NF) tick();

        // Back-to-back words with no bubble
        in_valid = 1'b1; in_data = 32'hA5A5A5A5;
        tick();
        in_data = 32'h0000000F;
        for (int k = 0; k < 2 * c_NF; k++) begin
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            if (k == c_NF) in_valid = 1'b0;
            tick();
        end
        chk("b2b_idle", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a word
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_index", {29'd0, out_index}, 32'd0);
        reset = 1'b1;
        in_valid = 1'b1; in_data = 32'h11111111;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < c_NF; k++) begin
            chk("ones_data", {28'd0, out_data}, 32'd1);
            chk("ones_index", {29'd0, out_index}, 32'(k));
            tick();
        end

        // Random traffic, backpressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            w         = $urandom;
            in_data   = w;
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 63) != 0);
            tick();
        end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (c_NF + 2) tick();

        // Byte-wide build
`ifdef UNGLOM_LSB_FIRST_EN
        exp8 = '{8'h78, 8'h56, 8'h34, 8'h12};
`else
        exp8 = '{8'h12, 8'h34, 8'h56, 8'h78};
`endif
        chk("b8_in_ready", {31'd0, b_in_ready}, 32'd1);
        b_in_valid = 1'b1; b_in_data = 32'h12345678;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("b8_valid", {31'd0, b_out_valid}, 32'd1);
            chk("b8_data", {24'd0, b_out_data}, {24'd0, exp8[k]});
            chk("b8_index", {30'd0, b_out_index}, 32'(k));
            chk("b8_last", {31'd0, b_out_last}, {31'd0, k == 3});
            @(posedge clk); #1;
        end
        chk("b8_idle", {31'd0, b_out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
